uart_tx_feeder: RTL
===================

# uart_tx_feeder

Buffered byte source that sits directly upstream of the UART transmit FSM/serializer. It accepts bytes from the system side into a small synchronous FIFO and, whenever the transmitter is idle, presents one byte with a single-cycle `tx_data_valid` pulse. It then tracks the transmitter's `Busy` handshake until the frame completes. Back-to-back frames leave exactly one idle cycle between frames.

## Interface
- `DATA_WIDTH`, 8: byte width; must match the serializer's parallel input.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `wr_data`  in  DATA_WIDTH  byte to enqueue.
- `wr_en`  in  1  enqueue request, sampled every `clk` edge.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set when a write is dropped because the FIFO is full.
- `tx_busy`  in  1  `Busy` from the UART TX FSM.
- `tx_data`  out  DATA_WIDTH  parallel data to the serializer.
- `tx_data_valid`  out  1  start request to the TX FSM (its `data_vaild` input).

## Operation
- Reset (`rst`=1 at an edge) produces these values:
  - FIFO pointers and `count` cleared; `empty`=1, `full`=0, `overflow`=0.
  - `tx_data`=0 and `tx_data_valid`=0.
  - State is `IDLE`.
- FIFO write: when `wr_en`=1 and `full`=0, `wr_data` is stored at the write pointer and `count`+1.
- FIFO write when full: when `wr_en`=1 and `full`=1, data is dropped, `overflow` is set, and pointers are unchanged. Only `rst` clears `overflow`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally modulo DEPTH. `full` and `empty` are derived from `count`.
- Pop occurs only on the IDLE→LAUNCH transition. A write and a pop in the same cycle leave `count` unchanged.
- Feeder FSM, states `IDLE`, `LAUNCH`, `WAIT_BUSY`, `WAIT_DONE`:
  - `IDLE`: if `empty`=0 and `tx_busy`=0 → `LAUNCH`. At the same edge: head entry loaded into `tx_data`, read pointer advances, `tx_data_valid`←1.
  - `LAUNCH`: `tx_data_valid`←0 unconditionally → `WAIT_BUSY`.
  - `WAIT_BUSY`: stay until `tx_busy`=1, then → `WAIT_DONE`.
  - `WAIT_DONE`: stay until `tx_busy`=0, then → `IDLE`.
  - Unreachable encodings → `IDLE`, with `tx_data_valid`=0.
- `tx_data` holds its value from the launch edge until the next launch; it is never modified mid-frame.
- A write into an empty FIFO while a frame is in flight is only buffered. It does not disturb the active frame.

## Timing
- `tx_data_valid` is registered and high for exactly one cycle per byte.
- Latency into an empty FIFO with `tx_busy`=0, write sampled at edge k:
  - `empty`=0 after k.
  - Launch at edge k+1; `tx_data_valid` high between k+1 and k+2.
- The TX FSM raises `Busy` in the cycle after `tx_data_valid`. The feeder is in `WAIT_BUSY` during that cycle and advances on the same edge that `Busy` is seen high.
- Inter-frame gap:
  - `Busy` is seen low at edge m, returning the feeder to `IDLE`.
  - The next launch is at edge m+1, giving one idle (stop-level) cycle between frames.
- `tx_busy`=1 while in `IDLE` blocks launch. Holding data never overrides an externally busy transmitter.
- `rst` mid-frame:
  - The FIFO contents and any in-flight byte are discarded; `tx_data_valid`=0 on the next cycle.
  - The TX FSM must be reset by the same domain.

## Structure
- Shared package `uart_pkg`:
  - `DATA_WIDTH` default.
  - Feeder state typedef (2-bit enum `IDLE`=0, `LAUNCH`=1, `WAIT_BUSY`=2, `WAIT_DONE`=3).
- One sub-module `uart_sync_fifo` (parameters `DATA_WIDTH`, `DEPTH`) containing storage, pointers, `count`, `full`/`empty` and `overflow`.
- The top module holds the feeder FSM and output registers and instantiates `uart_sync_fifo` once.

## Test plan
- Reset check: hold `rst` for 2 cycles → `empty`=1, `full`=0, `count`=0, `overflow`=0, `tx_data_valid`=0, `tx_data`=0.
- Single byte: write 0xA5 with `tx_busy`=0 → `tx_data`=0xA5 and a single-cycle `tx_data_valid` two edges after the write; `count` returns to 0.
- Burst of 3 (0x11, 0x22, 0x33) against the UART TX model (Busy for 11 cycles per frame):
  - Exactly three `tx_data_valid` pulses, in order, with `tx_data` stable through each frame.
  - One idle cycle between frames.
- Full/overflow (DEPTH=8, `tx_busy` forced 1):
  - Write 9 bytes → `full`=1 after the 8th, `count`=8, `overflow`=1 after the 9th.
  - After releasing `tx_busy`, bytes 1–8 come out in order and the 9th is never sent.
- Busy gating: `tx_busy`=1 while the FIFO is non-empty → no `tx_data_valid`. Drop `tx_busy` → launch on the next edge.
- Mid-frame reset: assert `rst` while in `WAIT_DONE` with 4 queued entries → `count`=0, `empty`=1, state `IDLE`, no further `tx_data_valid` after release with `tx_busy`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default byte width and the
// feeder state encoding.
package uart_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count and a sticky overflow flag.
// The head entry is presented combinationally so the consumer can register it.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  overflow_reg;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign overflow = overflow_reg;
  assign rd_data = mem[rd_ptr_reg];

  // A write to a full FIFO is dropped even if a pop happens on the same edge.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (wr_en && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes and hands them one at a time to the UART TX FSM, following its
// Busy handshake so each frame completes before the next launch.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_en,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    tx_busy,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_data_valid
);

  uart_pkg::feeder_state_e state_reg;
  logic [DATA_WIDTH-1:0]   head_data;
  logic                    pop;

  // The pop is tied to the launch decision so the FIFO and FSM never disagree.
  assign pop = (state_reg == uart_pkg::IDLE) && !empty && !tx_busy;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (pop),
    .rd_data  (head_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= uart_pkg::IDLE;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
    end else begin
      case (state_reg)
        uart_pkg::IDLE: begin
          tx_data_valid <= 1'b0;
          if (pop) begin
            tx_data       <= head_data;
            tx_data_valid <= 1'b1;
            state_reg     <= uart_pkg::LAUNCH;
          end
        end
        uart_pkg::LAUNCH: begin
          tx_data_valid <= 1'b0;
          state_reg     <= uart_pkg::WAIT_BUSY;
        end
        uart_pkg::WAIT_BUSY: begin
          tx_data_valid <= 1'b0;
          if (tx_busy) begin
            state_reg <= uart_pkg::WAIT_DONE;
          end
        end
        uart_pkg::WAIT_DONE: begin
          tx_data_valid <= 1'b0;
          if (!tx_busy) begin
            state_reg <= uart_pkg::IDLE;
          end
        end
        default: begin
          tx_data_valid <= 1'b0;
          state_reg     <= uart_pkg::IDLE;
        end
      endcase
    end
  end

endmodule
